// File: rtl/fofb_readout_sequencer_if.sv
// AXI-stream bundle carrying per-BPM X/Y position beats from the readout sequencer
// to the correction-matrix DSP.
interface fofb_readout_sequencer_if;
  logic        M_TVALID;
  logic        M_TREADY;
  logic [31:0] M_TDATA;
  logic [1:0]  M_TUSER;
  logic        M_TLAST;

  modport master (output M_TVALID, output M_TDATA, output M_TUSER, output M_TLAST, input M_TREADY);
  modport slave  (input M_TVALID, input M_TDATA, input M_TUSER, input M_TLAST, output M_TREADY);
endinterface

// File: rtl/fofb_readout_sequencer.sv
// Per-FA-cycle walk of the upstream readout DPRAMs, streaming X/Y per BPM as an AXI-stream frame.
// Optional reference-orbit subtraction is built when FOFB_SEQ_REF_SUBTRACT_EN is defined.
module fofb_readout_sequencer #(
  parameter int FOFB_INDEX_WIDTH = 9,
  parameter int FIFO_DEPTH       = 4
) (
  input  logic                        sysClk,
  input  logic                        sysReset,
  input  logic                        csrStrobe,
  input  logic                        refAddrStrobe,
  input  logic                        refDataStrobe,
  input  logic [31:0]                 GPIO_OUT,
  input  logic                        FAstrobe,
  input  logic                        readoutActive,
  input  logic                        readoutValid,
  output logic [FOFB_INDEX_WIDTH-1:0] fofbDSPreadoutAddress,
  input  logic [31:0]                 fofbDSPreadoutX,
  input  logic [31:0]                 fofbDSPreadoutY,
  input  logic [31:0]                 fofbDSPreadoutS,
  fofb_readout_sequencer_if.master    m_axis,
  output logic [31:0]                 status
);

  localparam int W  = FOFB_INDEX_WIDTH;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 2;
  localparam logic [W-1:0]  IDX_ONE = W'(1);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);
  localparam logic [AW:0]   CNT_ONE = (AW + 1)'(1);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_ARMED = 2'd1, S_WALK = 2'd2, S_DRAIN = 2'd3} state_e;

  typedef struct packed {
    logic        last;
    logic        fresh;
    logic [31:0] y;
    logic [31:0] x;
  } entry_t;

  state_e         state_q, state_d;
  logic           enable_q;
  logic [W-1:0]   bpm_count_q, frame_bpm_q, frame_bpm_d;
  logic [W-1:0]   idx_q, idx_d, addr_q, addr_d;
  logic           issue_q, issue_d, issue_last_q, issue_last_d;
  logic           inflight_q, inflight_last_q;
  logic           valid_dly_q, active_dly_q;
  logic [3:0]     overrun_q, overrun_d;
  logic [7:0]     timeout_q, timeout_d;
  logic [15:0]    frame_q, frame_d;

  entry_t         fifo_mem [FIFO_DEPTH];
  logic [AW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [AW:0]    fifo_count_q;
  logic           phase_q, out_valid_q, out_last_q;
  logic [31:0]    out_data_q;
  logic [1:0]     out_user_q;

  logic           valid_rise_s, active_fall_s, issue_ok_s, drain_done_s;
  logic           ld_s, pop_s, push_s;
  logic [CW-1:0]  pending_s;
  entry_t         head_s, push_entry_s;

`ifdef FOFB_SEQ_REF_SUBTRACT_EN
  logic [31:0]    ref_x_mem [2**W];
  logic [31:0]    ref_y_mem [2**W];
  logic [W:0]     ref_ptr_q;
  logic [31:0]    ref_x_rd_q, ref_y_rd_q;

  function automatic logic [31:0] sat_sub(input logic [31:0] a, input logic [31:0] b);
    logic [32:0] d;
    d = {a[31], a} - {b[31], b};
    if (d[32] != d[31]) begin
      sat_sub = d[32] ? 32'h8000_0000 : 32'h7FFF_FFFF;
    end else begin
      sat_sub = d[31:0];
    end
  endfunction

  // Reference pointer: bit W picks the plane, the index post-increments on each data write
  always_ff @(posedge sysClk) begin
    if (sysReset) begin
      ref_ptr_q <= '0;
    end else if (refAddrStrobe) begin
      ref_ptr_q <= GPIO_OUT[W:0];
    end else if (refDataStrobe) begin
      ref_ptr_q[W-1:0] <= ref_ptr_q[W-1:0] + IDX_ONE;
    end
  end

  // Reference RAMs; read with the issued address so the result lines up with upstream data
  always_ff @(posedge sysClk) begin
    if (refDataStrobe && !refAddrStrobe) begin
      if (ref_ptr_q[W]) ref_y_mem[ref_ptr_q[W-1:0]] <= GPIO_OUT;
      else              ref_x_mem[ref_ptr_q[W-1:0]] <= GPIO_OUT;
    end
    ref_x_rd_q <= ref_x_mem[addr_q];
    ref_y_rd_q <= ref_y_mem[addr_q];
  end

  assign push_entry_s = '{last: inflight_last_q, fresh: |fofbDSPreadoutS,
                          y: sat_sub(fofbDSPreadoutY, ref_y_rd_q),
                          x: sat_sub(fofbDSPreadoutX, ref_x_rd_q)};
`else
  logic unused_s;
  assign unused_s = &{1'b0, refAddrStrobe, refDataStrobe, GPIO_OUT[30:W]};
  assign push_entry_s = '{last: inflight_last_q, fresh: |fofbDSPreadoutS,
                          y: fofbDSPreadoutY, x: fofbDSPreadoutX};
`endif

  // A read counts against FIFO space from issue until its push, across both pipeline stages
  assign pending_s     = CW'(fifo_count_q) + CW'(issue_q) + CW'(inflight_q);
  assign issue_ok_s    = pending_s < CW'(FIFO_DEPTH);
  assign valid_rise_s  = readoutValid && !valid_dly_q;
  assign active_fall_s = !readoutActive && active_dly_q;
  assign push_s        = inflight_q;
  assign ld_s          = !out_valid_q || m_axis.M_TREADY;
  assign pop_s         = ld_s && phase_q && (fifo_count_q != '0);
  assign head_s        = fifo_mem[rd_ptr_q];
  assign drain_done_s  = (fifo_count_q == '0) && !issue_q && !inflight_q &&
                         (!out_valid_q || (m_axis.M_TREADY && out_last_q));

  // Next-state and walk/counter decisions
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    addr_d       = addr_q;
    issue_d      = 1'b0;
    issue_last_d = 1'b0;
    frame_bpm_d  = frame_bpm_q;
    timeout_d    = timeout_q;
    frame_d      = frame_q;
    if (FAstrobe && (state_q == S_WALK || state_q == S_DRAIN) && overrun_q != 4'hF) begin
      overrun_d = overrun_q + 4'd1;
    end else begin
      overrun_d = overrun_q;
    end
    case (state_q)
      S_IDLE: begin
        if (FAstrobe && enable_q) state_d = S_ARMED;
        else                      state_d = S_IDLE;
      end
      S_ARMED: begin
        if (valid_rise_s) begin
          state_d     = S_WALK;
          idx_d       = '0;
          frame_bpm_d = bpm_count_q;
        end else if (active_fall_s && !readoutValid) begin
          state_d = S_IDLE;
          if (timeout_q != 8'hFF) timeout_d = timeout_q + 8'd1;
          else                    timeout_d = timeout_q;
        end else begin
          state_d = S_ARMED;
        end
      end
      S_WALK: begin
        // idx == count means every BPM is issued: park one past the end so the last writeback fires
        if (idx_q == frame_bpm_q) begin
          addr_d  = idx_q;
          state_d = S_DRAIN;
        end else if (issue_ok_s) begin
          addr_d       = idx_q;
          idx_d        = idx_q + IDX_ONE;
          issue_d      = 1'b1;
          issue_last_d = (idx_q == frame_bpm_q - IDX_ONE);
        end else begin
          addr_d = addr_q;
        end
      end
      S_DRAIN: begin
        if (drain_done_s) begin
          state_d = S_IDLE;
          frame_d = frame_q + 16'd1;
        end else begin
          state_d = S_DRAIN;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Control, configuration and counter registers
  always_ff @(posedge sysClk) begin
    if (sysReset) begin
      state_q         <= S_IDLE;
      enable_q        <= 1'b0;
      bpm_count_q     <= '0;
      frame_bpm_q     <= '0;
      idx_q           <= '0;
      addr_q          <= '0;
      issue_q         <= 1'b0;
      issue_last_q    <= 1'b0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
      valid_dly_q     <= 1'b0;
      active_dly_q    <= 1'b0;
      overrun_q       <= 4'd0;
      timeout_q       <= 8'd0;
      frame_q         <= 16'd0;
    end else begin
      state_q         <= state_d;
      frame_bpm_q     <= frame_bpm_d;
      idx_q           <= idx_d;
      addr_q          <= addr_d;
      issue_q         <= issue_d;
      issue_last_q    <= issue_last_d;
      inflight_q      <= issue_q;
      inflight_last_q <= issue_last_q;
      valid_dly_q     <= readoutValid;
      active_dly_q    <= readoutActive;
      overrun_q       <= overrun_d;
      timeout_q       <= timeout_d;
      frame_q         <= frame_d;
      if (csrStrobe) begin
        bpm_count_q <= GPIO_OUT[W-1:0];
        enable_q    <= GPIO_OUT[31];
      end
    end
  end

  // Capture FIFO storage
  always_ff @(posedge sysClk) begin
    if (push_s && !sysReset) fifo_mem[wr_ptr_q] <= push_entry_s;
  end

  // FIFO pointers and the registered output beat (X then Y of the head entry)
  always_ff @(posedge sysClk) begin
    if (sysReset) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      fifo_count_q <= '0;
      phase_q      <= 1'b0;
      out_valid_q  <= 1'b0;
      out_data_q   <= 32'd0;
      out_user_q   <= 2'd0;
      out_last_q   <= 1'b0;
    end else begin
      if (push_s) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (pop_s)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
      case ({push_s, pop_s})
        2'b10:   fifo_count_q <= fifo_count_q + CNT_ONE;
        2'b01:   fifo_count_q <= fifo_count_q - CNT_ONE;
        default: fifo_count_q <= fifo_count_q;
      endcase
      if (ld_s) begin
        if (fifo_count_q != '0) begin
          out_valid_q <= 1'b1;
          out_data_q  <= phase_q ? head_s.y : head_s.x;
          out_user_q  <= {head_s.fresh, phase_q};
          out_last_q  <= phase_q & head_s.last;
          phase_q     <= ~phase_q;
        end else begin
          out_valid_q <= 1'b0;
        end
      end
    end
  end

  assign fofbDSPreadoutAddress = addr_q;
  assign m_axis.M_TVALID       = out_valid_q;
  assign m_axis.M_TDATA        = out_data_q;
  assign m_axis.M_TUSER        = out_user_q;
  assign m_axis.M_TLAST        = out_last_q;
  assign status                = {enable_q, state_q, 1'b0, overrun_q, timeout_q, frame_q};

endmodule

// File: tb/tb_fofb_readout_sequencer.sv
// Directed self-checking bench for fofb_readout_sequencer with a synchronous upstream DPRAM model.
module tb_fofb_readout_sequencer;
  logic        sysClk = 1'b0;
  logic        sysReset, csrStrobe, refAddrStrobe, refDataStrobe;
  logic [31:0] GPIO_OUT;
  logic        FAstrobe, readoutActive, readoutValid;
  logic [8:0]  addr;
  logic [31:0] upX, upY, upS, status;

  fofb_readout_sequencer_if m_if();

  fofb_readout_sequencer #(.FOFB_INDEX_WIDTH(9), .FIFO_DEPTH(4)) dut (
    .sysClk(sysClk), .sysReset(sysReset), .csrStrobe(csrStrobe),
    .refAddrStrobe(refAddrStrobe), .refDataStrobe(refDataStrobe), .GPIO_OUT(GPIO_OUT),
    .FAstrobe(FAstrobe), .readoutActive(readoutActive), .readoutValid(readoutValid),
    .fofbDSPreadoutAddress(addr), .fofbDSPreadoutX(upX), .fofbDSPreadoutY(upY),
    .fofbDSPreadoutS(upS), .m_axis(m_if), .status(status));

  always #5 sysClk = ~sysClk;

  int          checks = 0, failures = 0, addr_err = 0, stall_err = 0;
  logic [34:0] beats[$];
  logic [8:0]  addr_log[$];
  logic [8:0]  s_zero_idx = 9'h1FF;
  logic        ref_test = 1'b0;
  logic        prev_stall = 1'b0;
  logic [34:0] prev_beat = '0;
  logic [8:0]  prev_addr = '0;

  function automatic logic [31:0] xf(input logic [8:0] a);
    return 32'h0000_1000 + {23'd0, a};
  endfunction
  function automatic logic [31:0] yf(input logic [8:0] a);
    return 32'hFFFF_F000 - {23'd0, a};
  endfunction

  // Upstream DPRAM: data for the address presented in the previous cycle
  always @(posedge sysClk) begin
    upX <= (ref_test && addr == 9'd2) ? 32'd50 : xf(addr);
    upY <= (ref_test && addr == 9'd0) ? 32'h7FFF_FFFF : yf(addr);
    upS <= (addr == s_zero_idx) ? 32'd0 : 32'd1;
  end

  // Stream and address monitor
  always @(posedge sysClk) begin
    if (!sysReset && prev_stall &&
        !(m_if.M_TVALID && {m_if.M_TLAST, m_if.M_TUSER, m_if.M_TDATA} == prev_beat))
      stall_err++;
    prev_stall <= m_if.M_TVALID && !m_if.M_TREADY && !sysReset;
    prev_beat  <= {m_if.M_TLAST, m_if.M_TUSER, m_if.M_TDATA};
    if (m_if.M_TVALID && m_if.M_TREADY) beats.push_back({m_if.M_TLAST, m_if.M_TUSER, m_if.M_TDATA});
    if (addr != prev_addr) begin
      if (addr != prev_addr + 9'd1 && addr != 9'd0) addr_err++;
      addr_log.push_back(addr);
    end
    prev_addr <= addr;
  end

  task automatic step();
    @(posedge sysClk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] st();
    return status[30:29];
  endfunction

  task automatic cfg(input logic [31:0] v);
    GPIO_OUT = v; csrStrobe = 1'b1; step(); csrStrobe = 1'b0;
  endtask

  task automatic start_frame();
    readoutValid = 1'b0; readoutActive = 1'b1; step();
    FAstrobe = 1'b1; step(); FAstrobe = 1'b0;
    readoutValid = 1'b1; step();
  endtask

  task automatic wait_idle(input int budget, input logic rnd, input string tag);
    int n = 0;
    while (st() != 2'd0 && n < budget) begin
      if (rnd) m_if.M_TREADY = ($urandom_range(0, 99) < 30);
      step();
      n++;
    end
    m_if.M_TREADY = 1'b1;
    chk({tag, "_idle"}, st(), 2'd0);
  endtask

  task automatic check_frame(input int n, input string tag);
    logic fresh;
    chk({tag, "_nbeats"}, beats.size(), 2 * n);
    for (int i = 0; i < n && 2 * i + 1 < beats.size(); i++) begin
      fresh = (9'(i) != s_zero_idx);
      chk({tag, "_xdata"}, beats[2*i][31:0], xf(9'(i)));
      chk({tag, "_xmeta"}, beats[2*i][34:32], {1'b0, fresh, 1'b0});
      chk({tag, "_ydata"}, beats[2*i+1][31:0], yf(9'(i)));
      chk({tag, "_ymeta"}, beats[2*i+1][34:32], {(i == n - 1), fresh, 1'b1});
    end
    beats.delete();
  endtask

  initial begin
    sysReset = 1'b1; csrStrobe = 1'b0; refAddrStrobe = 1'b0; refDataStrobe = 1'b0;
    GPIO_OUT = 32'd0; FAstrobe = 1'b0; readoutActive = 1'b0; readoutValid = 1'b0;
    m_if.M_TREADY = 1'b1;
    step(); step();
    chk("rst_addr", addr, 9'd0);
    chk("rst_tvalid", m_if.M_TVALID, 1'b0);
    chk("rst_status", status, 32'd0);
    sysReset = 1'b0;
    step();
`ifdef FOFB_SEQ_REF_SUBTRACT_EN
    for (int p = 0; p < 2; p++) begin
      GPIO_OUT = (p == 0) ? 32'h0000_0000 : 32'h0000_0200;
      refAddrStrobe = 1'b1; step(); refAddrStrobe = 1'b0;
      GPIO_OUT = 32'd0;
      refDataStrobe = 1'b1;
      for (int k = 0; k < 16; k++) step();
      refDataStrobe = 1'b0;
    end
`endif

    // Test 1: three BPMs, continuous ready
    cfg(32'h8000_0003);
    chk("t1_cfg", status[31], 1'b1);
    start_frame();
    chk("t1_walk", st(), 2'd2);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("t1_addr", addr, 9'(i));
    end
    chk("t1_drain", st(), 2'd3);
    wait_idle(100, 1'b0, "t1");
    check_frame(3, "t1");
    chk("t1_framecnt", status[15:0], 16'd1);

    // Test 2: eight BPMs under random backpressure
    cfg(32'h8000_0008);
    addr_log.delete();
    start_frame();
    wait_idle(600, 1'b1, "t2");
    check_frame(8, "t2");
    chk("t2_nlog", addr_log.size(), 9);
    for (int i = 0; i < 9 && i < addr_log.size(); i++) chk("t2_addrseq", addr_log[i], 9'(i));
    chk("t2_framecnt", status[15:0], 16'd2);

    // Test 3: readout times out without valid
    cfg(32'h8000_0003);
    readoutValid = 1'b0; readoutActive = 1'b1; step();
    FAstrobe = 1'b1; step(); FAstrobe = 1'b0;
    chk("t3_armed", st(), 2'd1);
    readoutActive = 1'b0; step();
    chk("t3_idle", st(), 2'd0);
    chk("t3_timeout", status[23:16], 8'd1);
    step(); step();
    chk("t3_nobeats", beats.size(), 0);

    // Test 4: overrun while stalled
    m_if.M_TREADY = 1'b0;
    start_frame();
    FAstrobe = 1'b1; step(); FAstrobe = 1'b0;
    for (int i = 0; i < 6; i++) step();
    chk("t4_drain", st(), 2'd3);
    chk("t4_overrun", status[27:24], 4'd1);
    chk("t4_hold_valid", m_if.M_TVALID, 1'b1);
    chk("t4_hold_data", m_if.M_TDATA, xf(9'd0));
    chk("t4_hold_user", m_if.M_TUSER, 2'b10);
    m_if.M_TREADY = 1'b1;
    wait_idle(100, 1'b0, "t4");
    check_frame(3, "t4");
    chk("t4_framecnt", status[15:0], 16'd3);
    readoutValid = 1'b0; step();
    readoutValid = 1'b1;
    for (int i = 0; i < 5; i++) step();
    chk("t4_no_rearm", st(), 2'd0);
    chk("t4_nobeats", beats.size(), 0);
    chk("t4_framecnt2", status[15:0], 16'd3);

    // Test 5: stale BPM flagged, then reset mid-walk
    s_zero_idx = 9'd1;
    start_frame();
    wait_idle(100, 1'b0, "t5");
    check_frame(3, "t5");
    chk("t5_framecnt", status[15:0], 16'd4);
    s_zero_idx = 9'h1FF;
    m_if.M_TREADY = 1'b0;
    start_frame();
    for (int i = 0; i < 5; i++) step();
    chk("t5_pre_valid", m_if.M_TVALID, 1'b1);
    sysReset = 1'b1; step();
    chk("t5_rst_addr", addr, 9'd0);
    chk("t5_rst_tvalid", m_if.M_TVALID, 1'b0);
    chk("t5_rst_tdata", m_if.M_TDATA, 32'd0);
    chk("t5_rst_tuser", m_if.M_TUSER, 2'd0);
    chk("t5_rst_tlast", m_if.M_TLAST, 1'b0);
    chk("t5_rst_status", status, 32'd0);
    sysReset = 1'b0; m_if.M_TREADY = 1'b1; readoutValid = 1'b0;
    step();
    beats.delete();

`ifdef FOFB_SEQ_REF_SUBTRACT_EN
    // Test 6: reference subtraction with saturation
    cfg(32'h8000_0003);
    GPIO_OUT = 32'h0000_0002; refAddrStrobe = 1'b1; step(); refAddrStrobe = 1'b0;
    GPIO_OUT = 32'd100;       refDataStrobe = 1'b1; step(); refDataStrobe = 1'b0;
    GPIO_OUT = 32'h0000_0200; refAddrStrobe = 1'b1; step(); refAddrStrobe = 1'b0;
    GPIO_OUT = 32'hFFFF_FFFF; refDataStrobe = 1'b1; step(); refDataStrobe = 1'b0;
    ref_test = 1'b1;
    start_frame();
    wait_idle(100, 1'b0, "t6");
    ref_test = 1'b0;
    chk("t6_nbeats", beats.size(), 6);
    if (beats.size() == 6) begin
      chk("t6_x2_minus_ref", beats[4][31:0], 32'hFFFF_FFCE);
      chk("t6_y0_saturated", beats[1][31:0], 32'h7FFF_FFFF);
    end
    beats.delete();
`endif

    chk("addr_step_errors", addr_err, 0);
    chk("stall_stability_errors", stall_err, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
